axi_addr_arbiter: RTL
=====================

AXI_ADDR_ARBITER -- requirements
Module: axi_addr_arbiter

Interface
REQ-001 Parameter WQ_DEPTH, default 4, SHALL set the W-ownership queue depth; legal values are powers of two, 2..16.
REQ-002 Master index encoding SHALL be fixed: 0 = CPU master, 1 = DMA master.
REQ-003 Clocking and reset SHALL be one clock, with a synchronous, active-high reset.
REQ-004 clk_i  in  1  system clock; all state changes on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 aw_req_i  in  2  per-master AW valid (bit n = master n).
REQ-007 aw_hs_i  in  1  downstream AW handshake (awvalid && awready) of the granted request.
REQ-008 aw_gnt_o  out  2  one-hot-or-zero AW grant, registered.
REQ-009 ar_req_i  in  2  per-master AR valid.
REQ-010 ar_hs_i  in  1  downstream AR handshake of the granted request.
REQ-011 ar_gnt_o  out  2  one-hot-or-zero AR grant, registered.
REQ-012 w_last_hs_i  in  1  wvalid && wready && wlast on the shared W path.
REQ-013 w_sel_o  out  1  master index owning the current W burst (queue head).
REQ-014 w_sel_valid_o  out  1  queue non-empty; W path routed only while high.
REQ-015 wq_full_o  out  1  queue holds WQ_DEPTH entries.
REQ-016 wq_empty_o  out  1  queue holds zero entries.
REQ-017 err_o  out  1  sticky protocol-error flag.

Function
REQ-018 AW and AR SHALL each have an independent two-state FSM, IDLE and GRANT, and an independent 1-bit round-robin pointer.
REQ-019 In IDLE with any request set, the FSM SHALL select a winner and enter GRANT; the grant appears the next cycle (1-cycle latency).
REQ-020 Winner selection: a single requester wins; with both requesting, the master indexed by the pointer wins.
REQ-021 In GRANT, the grant SHALL stay constant until the channel handshake, even if the request deasserts.
REQ-022 On the handshake, the FSM SHALL return to IDLE with grant 0 the next cycle and set the pointer to the non-winner, so no back-to-back grant is possible (max one address per 2 cycles per channel).
REQ-023 The AW FSM SHALL NOT leave IDLE while wq_full_o = 1; AR is unaffected by queue state.
REQ-024 On aw_hs_i while in GRANT, the winner index SHALL be pushed to the queue tail.
REQ-025 On w_last_hs_i with the queue non-empty, the head SHALL be popped.
REQ-026 Simultaneous push and pop SHALL both take effect with the occupancy unchanged; this is legal at full.
REQ-027 w_sel_o SHALL equal the head entry when non-empty and 0 when empty.
REQ-028 Occupancy SHALL be tracked with a log2(WQ_DEPTH)+1 bit counter; read and write pointers wrap modulo WQ_DEPTH.
REQ-029 err_o SHALL set and hold on any of:
- aw_hs_i or ar_hs_i while that FSM is in IDLE;
- w_last_hs_i while the queue is empty (pop ignored);
- a push while full without a simultaneous pop (push dropped).
REQ-030 AW and AR SHALL never interact except through REQ-023; both may grant different masters in the same cycle.

Reset
REQ-031 With rst_i high at a clock edge, the next-cycle state SHALL be:
- both FSMs IDLE, both pointers 0 (CPU first);
- aw_gnt_o = ar_gnt_o = 2'b00;
- queue flushed: wq_empty_o = 1, wq_full_o = 0, w_sel_valid_o = 0, w_sel_o = 0;
- err_o = 0.
REQ-032 Reset asserted mid-grant or mid-burst SHALL discard the grant and queue contents with no handshake required; no output changes before the clock edge.
REQ-033 err_o SHALL clear only by reset.

Verification
REQ-034 The bench SHALL cover, out of reset, simultaneous requests: aw_req_i = 11 -> aw_gnt_o = 01 on cycle 1; aw_hs_i at cycle 3 -> grant 00 at cycle 4, then aw_gnt_o = 10 at cycle 5.
REQ-035 The bench SHALL cover a held grant: ar_req_i = 10 then 00 before handshake -> ar_gnt_o stays 10 until ar_hs_i, err_o stays 0.
REQ-036 The bench SHALL cover queue full with WQ_DEPTH = 4: four AW handshakes (0,1,0,1) with no w_last_hs_i -> wq_full_o = 1, a new aw_req_i gets no grant, w_sel_o = 0; one w_last_hs_i -> w_sel_o = 1, then a grant the following cycle.
REQ-037 The bench SHALL cover simultaneous push/pop at full: aw_hs_i and w_last_hs_i in the same cycle -> occupancy stays 4, err_o = 0, head advances.
REQ-038 The bench SHALL cover errors: w_last_hs_i with the queue empty -> err_o = 1 next cycle and held; then rst_i for 1 cycle -> err_o = 0.
REQ-039 The bench SHALL cover reset mid-operation: rst_i during an AW GRANT with 2 queue entries -> next cycle aw_gnt_o = 00, wq_empty_o = 1, pointer 0.

Source files
------------

// File: rtl/axi_addr_arbiter.sv
// Two-master AXI address arbiter: independent round-robin AW and AR
// arbiters plus a W-ownership queue recording AW winners in issue order.
module axi_addr_arbiter #(
   parameter int unsigned WQ_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] aw_req_i,
   input  logic       aw_hs_i,
   output logic [1:0] aw_gnt_o,
   input  logic [1:0] ar_req_i,
   input  logic       ar_hs_i,
   output logic [1:0] ar_gnt_o,
   input  logic       w_last_hs_i,
   output logic       w_sel_o,
   output logic       w_sel_valid_o,
   output logic       wq_full_o,
   output logic       wq_empty_o,
   output logic       err_o
);

   localparam int unsigned PW = $clog2(WQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          aw_state, aw_state_n;
   state_t          ar_state, ar_state_n;
   logic [1:0]      aw_gnt_n, ar_gnt_n;
   logic            aw_ptr, aw_ptr_n;
   logic            ar_ptr, ar_ptr_n;

   logic [WQ_DEPTH-1:0] wq_mem, wq_mem_n;
   logic [PW-1:0]       rd_ptr, rd_n, wr_ptr, wr_n;
   logic [CW-1:0]       wq_cnt, cnt_n;
   logic                err_n;

   logic q_full, q_empty, push, pop, push_ok;

   // Winner: a lone requester, otherwise the master the pointer favours.
   function automatic logic pick_win(input logic [1:0] req, input logic ptr);
      return (req == 2'b11) ? ptr : req[1];
   endfunction

   assign q_full  = (wq_cnt == CW'(WQ_DEPTH));
   assign q_empty = (wq_cnt == CW'(0));
   assign push    = aw_hs_i && (aw_state == GRANT);
   assign pop     = w_last_hs_i && !q_empty;
   assign push_ok = push && (!q_full || pop);

   // AW arbiter next state; stays idle while the W queue cannot take a winner.
   always_comb begin
      aw_state_n = aw_state;
      aw_gnt_n   = aw_gnt_o;
      aw_ptr_n   = aw_ptr;
      case (aw_state)
         IDLE: begin
            if ((|aw_req_i) && !q_full) begin
               aw_state_n = GRANT;
               aw_gnt_n   = pick_win(aw_req_i, aw_ptr) ? 2'b10 : 2'b01;
            end
         end
         GRANT: begin
            if (aw_hs_i) begin
               aw_state_n = IDLE;
               aw_gnt_n   = 2'b00;
               aw_ptr_n   = ~aw_gnt_o[1];
            end
         end
         default: aw_state_n = IDLE;
      endcase
   end

   // AR arbiter next state.
   always_comb begin
      ar_state_n = ar_state;
      ar_gnt_n   = ar_gnt_o;
      ar_ptr_n   = ar_ptr;
      case (ar_state)
         IDLE: begin
            if (|ar_req_i) begin
               ar_state_n = GRANT;
               ar_gnt_n   = pick_win(ar_req_i, ar_ptr) ? 2'b10 : 2'b01;
            end
         end
         GRANT: begin
            if (ar_hs_i) begin
               ar_state_n = IDLE;
               ar_gnt_n   = 2'b00;
               ar_ptr_n   = ~ar_gnt_o[1];
            end
         end
         default: ar_state_n = IDLE;
      endcase
   end

   // W-ownership queue update and sticky protocol-error detection.
   always_comb begin
      wq_mem_n = wq_mem;
      rd_n     = rd_ptr;
      wr_n     = wr_ptr;
      cnt_n    = wq_cnt;
      if (pop) begin
         rd_n = rd_ptr + PW'(1);
      end
      if (push_ok) begin
         wq_mem_n[wr_ptr] = aw_gnt_o[1];
         wr_n             = wr_ptr + PW'(1);
      end
      case ({push_ok, pop})
         2'b10:   cnt_n = wq_cnt + CW'(1);
         2'b01:   cnt_n = wq_cnt - CW'(1);
         default: cnt_n = wq_cnt;
      endcase
      err_n = err_o
            | (aw_hs_i && (aw_state == IDLE))
            | (ar_hs_i && (ar_state == IDLE))
            | (w_last_hs_i && q_empty)
            | (push && q_full && !pop);
   end

   // Arbiter state and grant registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_state <= IDLE;
         ar_state <= IDLE;
         aw_gnt_o <= 2'b00;
         ar_gnt_o <= 2'b00;
         aw_ptr   <= 1'b0;
         ar_ptr   <= 1'b0;
      end else begin
         aw_state <= aw_state_n;
         ar_state <= ar_state_n;
         aw_gnt_o <= aw_gnt_n;
         ar_gnt_o <= ar_gnt_n;
         aw_ptr   <= aw_ptr_n;
         ar_ptr   <= ar_ptr_n;
      end
   end

   // Queue storage, pointers, status outputs and error flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wq_mem        <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         wq_cnt        <= '0;
         w_sel_o       <= 1'b0;
         w_sel_valid_o <= 1'b0;
         wq_full_o     <= 1'b0;
         wq_empty_o    <= 1'b1;
         err_o         <= 1'b0;
      end else begin
         wq_mem        <= wq_mem_n;
         rd_ptr        <= rd_n;
         wr_ptr        <= wr_n;
         wq_cnt        <= cnt_n;
         w_sel_o       <= (cnt_n != CW'(0)) ? wq_mem_n[rd_n] : 1'b0;
         w_sel_valid_o <= (cnt_n != CW'(0));
         wq_full_o     <= (cnt_n == CW'(WQ_DEPTH));
         wq_empty_o    <= (cnt_n == CW'(0));
         err_o         <= err_n;
      end
   end

endmodule
